uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 217 +++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver with FF FF sync-word framing into a 128-bit payload.
// Optional inter-byte timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_frame_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         uart_rx,
    output logic [127:0] payload,
    output logic         payload_valid,
    output logic         frame_err,
    output logic         busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } samp_state_t;

    typedef enum logic [1:0] {
        F_HUNT0   = 2'd0,
        F_HUNT1   = 2'd1,
        F_PAYLOAD = 2'd2
    } frm_state_t;

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    samp_state_t      samp_q, samp_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_ok, byte_bad;

    frm_state_t   frm_q, frm_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [103:0] shadow_q, shadow_d;
    logic [127:0] payload_q, payload_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         tmo_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Byte sampler: shift_q holds the completed byte during the stop-sample cycle.
    always_comb begin
        samp_d    = samp_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        case (samp_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    samp_d    = S_START;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (bit_cnt_q == HALF_CNT) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    samp_d    = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_CNT) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        samp_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == LAST_CNT) begin
                    bit_cnt_d = '0;
                    samp_d    = S_IDLE;
                    byte_ok   = rx_sync_q;
                    byte_bad  = !rx_sync_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: samp_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q    <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            samp_q    <= samp_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = $clog2(TMO_CYC);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_run;

    // Down-counter reloaded on every accepted byte; only runs while the line is idle.
    assign tmo_run  = (frm_q != F_HUNT0) && (samp_q == S_IDLE);
    assign tmo_fire = tmo_run && (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        if (byte_ok) begin
            tmo_d = TMO_LOAD;
        end else if (tmo_run && (tmo_q != '0)) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        frm_d      = frm_q;
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        payload_d  = payload_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (byte_bad || tmo_fire) begin
            frm_d      = F_HUNT0;
            byte_cnt_d = '0;
            err_d      = 1'b1;
        end else if (byte_ok) begin
            case (frm_q)
                F_HUNT0: begin
                    if (shift_q == 8'hff) frm_d = F_HUNT1;
                end
                F_HUNT1: begin
                    byte_cnt_d = '0;
                    frm_d      = (shift_q == 8'hff) ? F_PAYLOAD : F_HUNT0;
                end
                F_PAYLOAD: begin
                    shadow_d = {shadow_q[95:0], shift_q};
                    if (byte_cnt_q == 4'd13) begin
                        payload_d  = {16'hffff, shadow_q, shift_q};
                        valid_d    = 1'b1;
                        byte_cnt_d = '0;
                        frm_d      = F_HUNT0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                default: frm_d = F_HUNT0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q      <= F_HUNT0;
            byte_cnt_q <= '0;
            shadow_q   <= '0;
            payload_q  <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            frm_q      <= frm_d;
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            payload_q  <= payload_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign payload       = payload_q;
    assign payload_valid = valid_q;
    assign frame_err     = err_q;
    assign busy          = (samp_q != S_IDLE) || (frm_q != F_HUNT0);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: table of byte streams plus hand-written corner sequences.
module tb_uart_frame_rx;

    localparam int CPB = 8;
    localparam int GAP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         uart_rx = 1'b1;
    logic [127:0] payload;
    logic         payload_valid;
    logic         frame_err;
    logic         busy;

    always #5 clk = ~clk;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .payload      (payload),
        .payload_valid(payload_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int valid_tot = 0;
    int err_tot   = 0;
    int both_tot  = 0;
    int busy_tot  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (payload_valid) valid_tot++;
            if (frame_err) err_tot++;
            if (payload_valid && frame_err) both_tot++;
            if (busy) busy_tot++;
        end
    end

    typedef struct {
        string        name;
        int           nbytes;
        logic [255:0] bytes;
        int           bad_idx;
        int           exp_valid;
        int           exp_err;
        logic [127:0] exp_payload;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(GAP);
    endtask

    function automatic logic [255:0] ramp(input logic [255:0] base, input int pos,
                                          input int n, input logic [7:0] first);
        logic [255:0] r;
        r = base;
        for (int i = 0; i < n; i++) r[8*(pos+i) +: 8] = first + 8'(i);
        return r;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, b0, s0;
        logic [255:0] r;

        vecs[0].name = "good";
        vecs[0].nbytes = 16;
        vecs[0].bytes = ramp(256'hffff, 2, 14, 8'h00);
        vecs[0].bad_idx = -1;
        vecs[0].exp_valid = 1;
        vecs[0].exp_err = 0;
        vecs[0].exp_payload = 128'hffff_0001_0203_0405_0607_0809_0a0b_0c0d;

        r = ramp(256'hffff, 2, 4, 8'h00);
        r[63:48] = 16'hffff;
        vecs[1].name = "badstop";
        vecs[1].nbytes = 22;
        vecs[1].bytes = ramp(r, 8, 14, 8'ha0);
        vecs[1].bad_idx = 5;
        vecs[1].exp_valid = 1;
        vecs[1].exp_err = 1;
        vecs[1].exp_payload = 128'hffff_a0a1_a2a3_a4a5_a6a7_a8a9_aaab_acad;

        r = '0;
        r[47:0] = 48'hffffff34ff12;
        vecs[2].name = "syncsearch";
        vecs[2].nbytes = 19;
        vecs[2].bytes = ramp(r, 6, 13, 8'h00);
        vecs[2].bad_idx = -1;
        vecs[2].exp_valid = 1;
        vecs[2].exp_err = 0;
        vecs[2].exp_payload = 128'hffff_ff00_0102_0304_0506_0708_090a_0b0c;

        r = ramp(256'hffff, 2, 14, 8'h10);
        r[143:128] = 16'hffff;
        vecs[3].name = "backtoback";
        vecs[3].nbytes = 32;
        vecs[3].bytes = ramp(r, 18, 14, 8'hf0);
        vecs[3].bad_idx = -1;
        vecs[3].exp_valid = 2;
        vecs[3].exp_err = 0;
        vecs[3].exp_payload = 128'hffff_f0f1_f2f3_f4f5_f6f7_f8f9_fafb_fcfd;

        tick(3);
        check("rst payload", payload, 128'h0);
        check("rst valid", 128'(payload_valid), 128'h0);
        check("rst err", 128'(frame_err), 128'h0);
        check("rst busy", 128'(busy), 128'h0);
        rst_n = 1'b1;
        tick(4);

        for (int k = 0; k < 4; k++) begin
            v0 = valid_tot;
            e0 = err_tot;
            s0 = both_tot;
            for (int j = 0; j < vecs[k].nbytes; j++) begin
                send_byte(vecs[k].bytes[8*j +: 8], j != vecs[k].bad_idx);
            end
            tick(4);
            check($sformatf("%s valid count", vecs[k].name), 128'(valid_tot - v0), 128'(vecs[k].exp_valid));
            check($sformatf("%s err count", vecs[k].name), 128'(err_tot - e0), 128'(vecs[k].exp_err));
            check($sformatf("%s payload", vecs[k].name), payload, vecs[k].exp_payload);
            check($sformatf("%s busy idle", vecs[k].name), 128'(busy), 128'h0);
            check($sformatf("%s valid+err overlap", vecs[k].name), 128'(both_tot - s0), 128'h0);
        end

        v0 = valid_tot;
        e0 = err_tot;
        b0 = busy_tot;
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(20);
        check("glitch busy seen", 128'(busy_tot != b0), 128'h1);
        check("glitch busy idle", 128'(busy), 128'h0);
        check("glitch valid", 128'(valid_tot - v0), 128'h0);
        check("glitch err", 128'(err_tot - e0), 128'h0);
        check("glitch payload held", payload, 128'hffff_f0f1_f2f3_f4f5_f6f7_f8f9_fafb_fcfd);

        r = ramp(256'hffff, 2, 7, 8'h00);
        for (int j = 0; j < 9; j++) send_byte(r[8*j +: 8], 1'b1);
        uart_rx = 1'b0;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
        uart_rx = 1'b0;
        tick(CPB);
        rst_n = 1'b0;
        #2;
        check("midrst payload", payload, 128'h0);
        check("midrst valid", 128'(payload_valid), 128'h0);
        check("midrst err", 128'(frame_err), 128'h0);
        check("midrst busy", 128'(busy), 128'h0);
        uart_rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        v0 = valid_tot;
        e0 = err_tot;
        r = ramp(256'hffff, 2, 14, 8'h20);
        for (int j = 0; j < 16; j++) send_byte(r[8*j +: 8], 1'b1);
        tick(4);
        check("postrst valid count", 128'(valid_tot - v0), 128'h1);
        check("postrst err count", 128'(err_tot - e0), 128'h0);
        check("postrst payload", payload, 128'hffff_2021_2223_2425_2627_2829_2a2b_2c2d);

`ifdef UART_RX_TIMEOUT_EN
        e0 = err_tot;
        send_byte(8'hff, 1'b1);
        send_byte(8'hff, 1'b1);
        tick(150);
        check("timeout early", 128'(err_tot - e0), 128'h0);
        tick(50);
        check("timeout err", 128'(err_tot - e0), 128'h1);
        check("timeout busy", 128'(busy), 128'h0);
        v0 = valid_tot;
        r = ramp(256'hffff, 2, 14, 8'h40);
        for (int j = 0; j < 16; j++) send_byte(r[8*j +: 8], 1'b1);
        tick(4);
        check("timeout next valid", 128'(valid_tot - v0), 128'h1);
        check("timeout next payload", payload, 128'hffff_4041_4243_4445_4647_4849_4a4b_4c4d);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
